// File: rtl/jtframe_frame_monitor_if.sv
// Pixel-stream tap bundle for jtframe_frame_monitor.
// Carries the core's raw video: pixel clock enable, blanking and RGB.
interface jtframe_frame_monitor_if #(
  parameter int COLORW = 4
);
  logic              pxl_cen;
  logic              hb;
  logic              vb;
  logic [COLORW-1:0] red;
  logic [COLORW-1:0] green;
  logic [COLORW-1:0] blue;

  // master drives the video stream, slave only observes it
  modport master (output pxl_cen, hb, vb, red, green, blue);
  modport slave  (input  pxl_cen, hb, vb, red, green, blue);
endinterface

// File: rtl/jtframe_frame_monitor.sv
// jtframe_frame_monitor: frame counter / geometry checker for a pixel stream.
// Counts frames, measures active pixels per line and active lines per frame,
// flags geometry changes once locked, and optionally signs every frame with a
// CRC-16/CCITT over the active pixels.
// Optional feature macro: JTFRAME_FRAME_CRC_EN (defined = CRC logic present,
// undefined = crc_o tied to zero).
//
// Handshake: the video tap has no back-pressure. A sample is taken on every
// clk edge where vid.pxl_cen is high; hb/vb/RGB are don't-care otherwise.
module jtframe_frame_monitor #(
  parameter int COLORW = 4,
  parameter int FRAMEW = 32,
  parameter int HCNTW  = 10,
  parameter int VCNTW  = 9,
  parameter int SKIP   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtframe_frame_monitor_if.slave vid,
  output logic [FRAMEW-1:0]     frame_cnt_o,
  output logic                  frame_done_o,
  output logic [HCNTW-1:0]      hactive_o,
  output logic [VCNTW-1:0]      vactive_o,
  output logic                  geom_err_o,
  output logic [15:0]           crc_o,
  output logic                  locked_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t            state_q;
  logic              hb_l_q, vb_l_q;
  logic [HCNTW-1:0]  pix_cnt_q, hactive_tmp_q, hactive_q;
  logic [VCNTW-1:0]  line_cnt_q, vactive_q;
  logic [FRAMEW-1:0] frame_cnt_q;
  logic              frame_done_q, geom_err_q, locked_q;

  logic              hb_rise, vb_rise, vb_fall;
  logic              in_active, pix_take, line_close, frame_close;
  logic [HCNTW-1:0]  pix_cnt_d, hactive_tmp_d;
  logic [VCNTW-1:0]  line_cnt_d;
  logic [FRAMEW-1:0] frame_cnt_d;
  logic              geom_diff;

  // Edge detection and next values of the line/frame measurement counters.
  // A line close (hb rise) is folded into line_cnt_d/hactive_tmp_d so that a
  // frame close on the same sample sees the line already counted.
  always_comb begin
    hb_rise       = vid.hb & ~hb_l_q;
    vb_rise       = vid.vb & ~vb_l_q;
    vb_fall       = ~vid.vb & vb_l_q;
    in_active     = vid.pxl_cen && (state_q == ST_ACTIVE);
    pix_take      = in_active & ~vid.hb & ~vid.vb;
    line_close    = in_active & hb_rise;
    frame_close   = in_active & vb_rise;
    pix_cnt_d     = pix_cnt_q;
    if (line_close) begin
      pix_cnt_d = '0;
    end else if (pix_take && !(&pix_cnt_q)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    hactive_tmp_d = line_close ? pix_cnt_q : hactive_tmp_q;
    line_cnt_d    = line_cnt_q;
    if (line_close && (pix_cnt_q != '0) && !(&line_cnt_q)) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end
    frame_cnt_d   = frame_cnt_q + 1'b1;
    geom_diff     = (hactive_tmp_d != hactive_q) || (line_cnt_d != vactive_q);
  end

`ifdef JTFRAME_FRAME_CRC_EN
  logic [15:0] crc_q, crc_out_q, crc_d;

  // CRC-16/CCITT (poly 1021), MSB first, all pixel bits folded in one step
  function automatic logic [15:0] crc_fold(input logic [15:0]         c,
                                           input logic [3*COLORW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 3*COLORW-1; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Running frame signature: advances only on counted active pixels
  always_comb begin
    crc_d = crc_q;
    if (pix_take) crc_d = crc_fold(crc_q, {vid.red, vid.green, vid.blue});
  end

  assign crc_o = crc_out_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{vid.red, vid.green, vid.blue};
  assign crc_o      = 16'h0000;
`endif

  // Frame tracking FSM with registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_SYNC;
      hb_l_q        <= 1'b0;
      vb_l_q        <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      hactive_tmp_q <= '0;
      hactive_q     <= '0;
      vactive_q     <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      geom_err_q    <= 1'b0;
      locked_q      <= 1'b0;
`ifdef JTFRAME_FRAME_CRC_EN
      crc_q         <= 16'hFFFF;
      crc_out_q     <= 16'h0000;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (vid.pxl_cen) begin
        hb_l_q <= vid.hb;
        vb_l_q <= vid.vb;
      end
      case (state_q)
        ST_SYNC: begin
          if (vid.pxl_cen && vb_rise) state_q <= ST_BLANK;
        end
        ST_BLANK: begin
          if (vid.pxl_cen && vb_fall) begin
            state_q       <= ST_ACTIVE;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            hactive_tmp_q <= '0;
`ifdef JTFRAME_FRAME_CRC_EN
            crc_q         <= 16'hFFFF;
`endif
          end
        end
        ST_ACTIVE: begin
          pix_cnt_q     <= pix_cnt_d;
          line_cnt_q    <= line_cnt_d;
          hactive_tmp_q <= hactive_tmp_d;
`ifdef JTFRAME_FRAME_CRC_EN
          crc_q         <= crc_d;
`endif
          if (frame_close) begin
            state_q      <= ST_BLANK;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_d;
            hactive_q    <= hactive_tmp_d;
            vactive_q    <= line_cnt_d;
`ifdef JTFRAME_FRAME_CRC_EN
            crc_out_q    <= crc_d;
`endif
            // compare against the previous frame only once already locked
            if (locked_q && geom_diff) geom_err_q <= 1'b1;
            if (frame_cnt_d == FRAMEW'(SKIP)) locked_q <= 1'b1;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign frame_cnt_o  = frame_cnt_q;
  assign frame_done_o = frame_done_q;
  assign hactive_o    = hactive_q;
  assign vactive_o    = vactive_q;
  assign geom_err_o   = geom_err_q;
  assign locked_o     = locked_q;
  assign state_o      = state_q;

endmodule
